pipe_control_unit: RTL and testbench
====================================

PIPE_CONTROL_UNIT -- requirements
Module: pipe_control_unit

Interface
REQ-001 SHALL have parameter CNT_W, default 32: width of the performance counters.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its posedge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have port start, input, 1 bit: one-cycle pulse that starts execution from IDLE.
REQ-005 SHALL have port D_icode, input, 4 bits: icode held in the decode register.
REQ-006 SHALL have ports d_srcA and d_srcB, input, 4 bits each: decode source registers; 4'hF means none.
REQ-007 SHALL have port E_icode, input, 4 bits: icode held in the execute register.
REQ-008 SHALL have port E_dstM, input, 4 bits: memory destination in the execute register.
REQ-009 SHALL have port e_Cnd, input, 1 bit: branch condition computed in execute.
REQ-010 SHALL have port M_icode, input, 4 bits: icode held in the memory register.
REQ-011 SHALL have port m_stat, input, 3 bits: status leaving the memory stage.
REQ-012 SHALL have port W_stat, input, 3 bits: status held in the writeback register.
REQ-013 SHALL have outputs F_stall, D_stall, D_bubble, E_bubble, M_bubble and W_stall, 1 bit each: stage controls.
REQ-014 SHALL have output halted, 1 bit: processor stopped.
REQ-015 SHALL have output final_stat, 3 bits: W_stat captured when HALT was entered.
REQ-016 SHALL have outputs cycle_cnt, lu_cnt and mp_cnt, CNT_W bits each: count of RUN/DRAIN cycles, load-use stall cycles and mispredict cycles.

Function
REQ-017 SHALL use stat codes BUB=0, AOK=1, HLT=2, ADR=3, INS=4; "exceptional" means HLT, ADR or INS.
REQ-018 SHALL use icodes: MRMOVQ=5, JXX=7, RET=9, POPQ=B.
REQ-019 SHALL derive the following combinationally in the same cycle:
- lu = (E_icode is MRMOVQ or POPQ) and E_dstM != F and E_dstM equals d_srcA or d_srcB.
- mp = (E_icode == JXX) and !e_Cnd.
- rt = RET appears in D_icode, E_icode or M_icode.
REQ-020 SHALL implement a registered FSM with states IDLE, RUN, DRAIN and HALT.
REQ-021 SHALL drive the stage controls in RUN as:
- F_stall = lu | rt
- D_stall = lu
- D_bubble = mp | (rt & !lu)
- E_bubble = mp | lu
- M_bubble = exceptional(m_stat) | exceptional(W_stat)
- W_stall = exceptional(W_stat)
REQ-022 SHALL, in IDLE, drive F_stall, D_bubble, E_bubble and M_bubble to 1 and D_stall and W_stall to 0, flushing bubbles into the pipeline.
REQ-023 SHALL, in DRAIN, drive F_stall, D_stall, E_bubble and M_bubble to 1 and W_stall = exceptional(W_stat).
REQ-024 SHALL, in HALT, drive F_stall, D_stall and W_stall to 1 and all bubble outputs to 0, freezing the pipeline.
REQ-025 SHALL take these transitions:
- IDLE to RUN on start.
- RUN to HALT if W_stat is exceptional.
- Otherwise RUN to DRAIN if m_stat is exceptional.
- DRAIN to HALT when W_stat is exceptional.
- HALT is terminal until reset; start is ignored outside IDLE.
REQ-026 SHALL capture final_stat from W_stat on the edge that enters HALT, and hold halted=1 from the following cycle.
REQ-027 SHALL increment cycle_cnt on every cycle in RUN or DRAIN.
REQ-028 SHALL increment lu_cnt on RUN cycles with lu=1, and mp_cnt on RUN cycles with mp=1.
REQ-029 SHALL saturate all counters at all-ones, with no wrap-around.
REQ-030 SHALL clear all counters and final_stat on the edge where start is accepted in IDLE.
REQ-031 SHALL resolve simultaneous lu and rt as stall F and D plus bubble E (no D bubble).

Reset
REQ-032 SHALL, on rst_n=0 at a posedge, set state to IDLE, all counters to 0, final_stat to 0 and halted to 0, overriding any state including mid-DRAIN.
REQ-033 SHALL present the IDLE control pattern on the stage outputs while in reset.

Structure
REQ-034 SHALL place icode constants, stat codes, RNONE=4'hF and the FSM state enum in the shared package y86_pipe_pkg.
REQ-035 SHALL implement the lu, mp and rt detection in the combinational sub-module pipe_hazard_detect.

Verification
REQ-036 SHALL verify load-use: E_icode=5, E_dstM=3, d_srcA=3 in RUN -> F_stall=1, D_stall=1, E_bubble=1, D_bubble=0, lu_cnt+1.
REQ-037 SHALL verify mispredict: E_icode=7, e_Cnd=0 -> D_bubble=1, E_bubble=1, F_stall=0, mp_cnt+1.
REQ-038 SHALL verify ret plus load-use: D_icode=9 with lu true -> F_stall=1, D_stall=1, E_bubble=1, D_bubble=0.
REQ-039 SHALL verify exception drain: m_stat=3 -> DRAIN next cycle, M_bubble=1; then W_stat=3 -> halted=1, final_stat=3, W_stall=1, cycle_cnt frozen.
REQ-040 SHALL verify reset during DRAIN: rst_n=0 for one edge -> IDLE pattern, counters 0; start in HALT ignored.
REQ-041 SHALL verify saturation with CNT_W=4: run 20 cycles -> cycle_cnt holds 4'hF.

Source files
------------

// File: rtl/y86_pipe_pkg.sv
// Shared definitions for the Y86 pipeline control slice: instruction codes,
// status codes, the register "none" marker and the control FSM state type.
package y86_pipe_pkg;

    localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
    localparam logic [3:0] ICODE_JXX    = 4'h7;
    localparam logic [3:0] ICODE_RET    = 4'h9;
    localparam logic [3:0] ICODE_POPQ   = 4'hB;

    localparam logic [3:0] RNONE = 4'hF;

    localparam logic [2:0] STAT_BUB = 3'd0;
    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HALT  = 2'd3
    } pcu_state_t;

    typedef struct packed {
        logic f_stall;
        logic d_stall;
        logic d_bubble;
        logic e_bubble;
        logic m_bubble;
        logic w_stall;
    } stage_ctrl_t;

    // Pattern that pushes bubbles into every stage while fetch is held.
    localparam stage_ctrl_t CTRL_IDLE = '{
        f_stall:  1'b1,
        d_stall:  1'b0,
        d_bubble: 1'b1,
        e_bubble: 1'b1,
        m_bubble: 1'b1,
        w_stall:  1'b0
    };

    localparam stage_ctrl_t CTRL_HALT = '{
        f_stall:  1'b1,
        d_stall:  1'b1,
        d_bubble: 1'b0,
        e_bubble: 1'b0,
        m_bubble: 1'b0,
        w_stall:  1'b1
    };

    function automatic logic stat_is_exc(input logic [2:0] stat);
        return (stat == STAT_HLT) || (stat == STAT_ADR) || (stat == STAT_INS);
    endfunction

endpackage

// File: rtl/pipe_hazard_detect.sv
// Combinational hazard detection: load-use, branch mispredict and ret in flight.
module pipe_hazard_detect
    import y86_pipe_pkg::*;
(
    input  logic [3:0] d_icode_i,
    input  logic [3:0] d_src_a_i,
    input  logic [3:0] d_src_b_i,
    input  logic [3:0] e_icode_i,
    input  logic [3:0] e_dst_m_i,
    input  logic       e_cnd_i,
    input  logic [3:0] m_icode_i,
    output logic       lu_o,
    output logic       mp_o,
    output logic       rt_o
);

    logic e_is_load;
    logic dst_hits_src;

    always_comb begin
        e_is_load    = (e_icode_i == ICODE_MRMOVQ) || (e_icode_i == ICODE_POPQ);
        // A load with no real destination can never feed decode.
        dst_hits_src = (e_dst_m_i != RNONE) &&
                       ((e_dst_m_i == d_src_a_i) || (e_dst_m_i == d_src_b_i));

        lu_o = e_is_load && dst_hits_src;
        mp_o = (e_icode_i == ICODE_JXX) && !e_cnd_i;
        rt_o = (d_icode_i == ICODE_RET) ||
               (e_icode_i == ICODE_RET) ||
               (m_icode_i == ICODE_RET);
    end

endmodule

// File: rtl/pipe_control_unit.sv
// Pipeline control unit: run/drain/halt sequencing, stage stall/bubble
// generation and saturating performance counters.
module pipe_control_unit
    import y86_pipe_pkg::*;
#(
    parameter int CNT_W = 32
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       D_icode,
    input  logic [3:0]       d_srcA,
    input  logic [3:0]       d_srcB,
    input  logic [3:0]       E_icode,
    input  logic [3:0]       E_dstM,
    input  logic             e_Cnd,
    input  logic [3:0]       M_icode,
    input  logic [2:0]       m_stat,
    input  logic [2:0]       W_stat,
    output logic             F_stall,
    output logic             D_stall,
    output logic             D_bubble,
    output logic             E_bubble,
    output logic             M_bubble,
    output logic             W_stall,
    output logic             halted,
    output logic [2:0]       final_stat,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] lu_cnt,
    output logic [CNT_W-1:0] mp_cnt,
    output pcu_state_t       dbg_state
);

    pcu_state_t       state_q, state_d;
    logic             halted_q, halted_d;
    logic [2:0]       final_stat_q, final_stat_d;
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [CNT_W-1:0] lu_cnt_q, lu_cnt_d;
    logic [CNT_W-1:0] mp_cnt_q, mp_cnt_d;

    logic        lu, mp, rt;
    logic        w_exc, m_exc;
    stage_ctrl_t ctrl;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    pipe_hazard_detect u_hazard (
        .d_icode_i (D_icode),
        .d_src_a_i (d_srcA),
        .d_src_b_i (d_srcB),
        .e_icode_i (E_icode),
        .e_dst_m_i (E_dstM),
        .e_cnd_i   (e_Cnd),
        .m_icode_i (M_icode),
        .lu_o      (lu),
        .mp_o      (mp),
        .rt_o      (rt)
    );

    assign w_exc = stat_is_exc(W_stat);
    assign m_exc = stat_is_exc(m_stat);

    // Stage controls follow the current state and this cycle's hazards.
    always_comb begin
        ctrl = CTRL_IDLE;
        if (rst_n) begin
            case (state_q)
                ST_RUN: begin
                    ctrl.f_stall  = lu | rt;
                    ctrl.d_stall  = lu;
                    ctrl.d_bubble = mp | (rt & ~lu);
                    ctrl.e_bubble = mp | lu;
                    ctrl.m_bubble = m_exc | w_exc;
                    ctrl.w_stall  = w_exc;
                end
                ST_DRAIN: begin
                    ctrl.f_stall  = 1'b1;
                    ctrl.d_stall  = 1'b1;
                    ctrl.d_bubble = 1'b0;
                    ctrl.e_bubble = 1'b1;
                    ctrl.m_bubble = 1'b1;
                    ctrl.w_stall  = w_exc;
                end
                ST_HALT:  ctrl = CTRL_HALT;
                default:  ctrl = CTRL_IDLE;
            endcase
        end
    end

    always_comb begin
        state_d      = state_q;
        halted_d     = halted_q;
        final_stat_d = final_stat_q;
        cycle_cnt_d  = cycle_cnt_q;
        lu_cnt_d     = lu_cnt_q;
        mp_cnt_d     = mp_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d      = ST_RUN;
                    final_stat_d = STAT_BUB;
                    cycle_cnt_d  = '0;
                    lu_cnt_d     = '0;
                    mp_cnt_d     = '0;
                end
            end
            ST_RUN: begin
                cycle_cnt_d = sat_inc(cycle_cnt_q);
                if (lu) lu_cnt_d = sat_inc(lu_cnt_q);
                if (mp) mp_cnt_d = sat_inc(mp_cnt_q);
                // A fault already in writeback wins over one still in memory.
                if (w_exc) begin
                    state_d      = ST_HALT;
                    halted_d     = 1'b1;
                    final_stat_d = W_stat;
                end else if (m_exc) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                cycle_cnt_d = sat_inc(cycle_cnt_q);
                if (w_exc) begin
                    state_d      = ST_HALT;
                    halted_d     = 1'b1;
                    final_stat_d = W_stat;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            halted_q     <= 1'b0;
            final_stat_q <= STAT_BUB;
            cycle_cnt_q  <= '0;
            lu_cnt_q     <= '0;
            mp_cnt_q     <= '0;
        end else begin
            state_q      <= state_d;
            halted_q     <= halted_d;
            final_stat_q <= final_stat_d;
            cycle_cnt_q  <= cycle_cnt_d;
            lu_cnt_q     <= lu_cnt_d;
            mp_cnt_q     <= mp_cnt_d;
        end
    end

    assign F_stall    = ctrl.f_stall;
    assign D_stall    = ctrl.d_stall;
    assign D_bubble   = ctrl.d_bubble;
    assign E_bubble   = ctrl.e_bubble;
    assign M_bubble   = ctrl.m_bubble;
    assign W_stall    = ctrl.w_stall;
    assign halted     = halted_q;
    assign final_stat = final_stat_q;
    assign cycle_cnt  = cycle_cnt_q;
    assign lu_cnt     = lu_cnt_q;
    assign mp_cnt     = mp_cnt_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_pipe_control_unit.sv
// Bench for pipe_control_unit: a 32-bit and a 4-bit counter instance share
// stimulus; a mode-level reference model feeds a queue drained by a monitor.
module tb_pipe_control_unit;

    localparam int CLK_HALF = 5;

    localparam int MODE_IDLE  = 0;
    localparam int MODE_RUN   = 1;
    localparam int MODE_DRAIN = 2;
    localparam int MODE_HALT  = 3;

    typedef struct packed {
        logic [5:0]  ctrl;
        logic        halted;
        logic [2:0]  fstat;
        logic [31:0] cyc;
        logic [31:0] lu;
        logic [31:0] mp;
        logic [3:0]  cyc4;
        logic [3:0]  lu4;
        logic [3:0]  mp4;
    } exp_t;

    localparam int EXP_W = $bits(exp_t);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic [3:0] D_icode = 4'h1, d_srcA = 4'hF, d_srcB = 4'hF;
    logic [3:0] E_icode = 4'h1, E_dstM = 4'hF, M_icode = 4'h1;
    logic e_Cnd = 1'b1;
    logic [2:0] m_stat = 3'd1, W_stat = 3'd1;

    logic F_stall_a, D_stall_a, D_bubble_a, E_bubble_a, M_bubble_a, W_stall_a;
    logic halted_a;
    logic [2:0] final_stat_a;
    logic [31:0] cycle_cnt_a, lu_cnt_a, mp_cnt_a;
    logic [1:0] dbg_state_a;

    logic F_stall_s, D_stall_s, D_bubble_s, E_bubble_s, M_bubble_s, W_stall_s;
    logic halted_s;
    logic [2:0] final_stat_s;
    logic [3:0] cycle_cnt_s, lu_cnt_s, mp_cnt_s;
    logic [1:0] dbg_state_s;

    logic [EXP_W-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail = 0;

    int         md_mode;
    longint     md_cyc, md_lu, md_mp;
    logic [2:0] md_fstat;
    logic       md_halted;

    always #CLK_HALF clk = ~clk;

    pipe_control_unit #(.CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
        .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd),
        .M_icode(M_icode), .m_stat(m_stat), .W_stat(W_stat),
        .F_stall(F_stall_a), .D_stall(D_stall_a), .D_bubble(D_bubble_a),
        .E_bubble(E_bubble_a), .M_bubble(M_bubble_a), .W_stall(W_stall_a),
        .halted(halted_a), .final_stat(final_stat_a),
        .cycle_cnt(cycle_cnt_a), .lu_cnt(lu_cnt_a), .mp_cnt(mp_cnt_a),
        .dbg_state(dbg_state_a)
    );

    pipe_control_unit #(.CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n), .start(start),
        .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
        .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd),
        .M_icode(M_icode), .m_stat(m_stat), .W_stat(W_stat),
        .F_stall(F_stall_s), .D_stall(D_stall_s), .D_bubble(D_bubble_s),
        .E_bubble(E_bubble_s), .M_bubble(M_bubble_s), .W_stall(W_stall_s),
        .halted(halted_s), .final_stat(final_stat_s),
        .cycle_cnt(cycle_cnt_s), .lu_cnt(lu_cnt_s), .mp_cnt(mp_cnt_s),
        .dbg_state(dbg_state_s)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_exc(input logic [2:0] s);
        return s inside {3'd2, 3'd3, 3'd4};
    endfunction

    function automatic longint clamp(input longint v, input int w);
        longint mx;
        mx = (longint'(1) << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    // Expected outputs for the cycle about to be sampled, from the model's mode.
    function automatic exp_t model_out(input logic rst_v, input logic [3:0] di, sa, sb,
                                       input logic [3:0] ei, edm, input logic ec,
                                       input logic [3:0] mi, input logic [2:0] ms, ws);
        exp_t e;
        bit lu, mp, rt;
        int mode;
        lu = (ei == 4'h5 || ei == 4'hB) && edm != 4'hF && (edm == sa || edm == sb);
        mp = (ei == 4'h7) && !ec;
        rt = (di == 4'h9) || (ei == 4'h9) || (mi == 4'h9);
        mode = rst_v ? md_mode : MODE_IDLE;
        case (mode)
            MODE_RUN:   e.ctrl = {lu | rt, lu, mp | (rt & !lu), mp | lu,
                                  is_exc(ms) | is_exc(ws), is_exc(ws)};
            MODE_DRAIN: e.ctrl = {1'b1, 1'b1, 1'b0, 1'b1, 1'b1, is_exc(ws)};
            MODE_HALT:  e.ctrl = 6'b110001;
            default:    e.ctrl = 6'b101110;
        endcase
        e.halted = md_halted;
        e.fstat  = md_fstat;
        e.cyc    = 32'(clamp(md_cyc, 32));
        e.lu     = 32'(clamp(md_lu, 32));
        e.mp     = 32'(clamp(md_mp, 32));
        e.cyc4   = 4'(clamp(md_cyc, 4));
        e.lu4    = 4'(clamp(md_lu, 4));
        e.mp4    = 4'(clamp(md_mp, 4));
        return e;
    endfunction

    task automatic model_advance(input logic rst_v, input logic st, input logic [3:0] di, sa, sb,
                                 input logic [3:0] ei, edm, input logic ec,
                                 input logic [3:0] mi, input logic [2:0] ms, ws);
        bit lu, mp;
        lu = (ei == 4'h5 || ei == 4'hB) && edm != 4'hF && (edm == sa || edm == sb);
        mp = (ei == 4'h7) && !ec;
        if (!rst_v) begin
            md_mode = MODE_IDLE; md_cyc = 0; md_lu = 0; md_mp = 0;
            md_fstat = 3'd0; md_halted = 1'b0;
        end else if (md_mode == MODE_IDLE) begin
            if (st) begin
                md_mode = MODE_RUN; md_cyc = 0; md_lu = 0; md_mp = 0; md_fstat = 3'd0;
            end
        end else if (md_mode == MODE_RUN || md_mode == MODE_DRAIN) begin
            md_cyc++;
            if (md_mode == MODE_RUN && lu) md_lu++;
            if (md_mode == MODE_RUN && mp) md_mp++;
            if (is_exc(ws)) begin
                md_mode = MODE_HALT; md_fstat = ws; md_halted = 1'b1;
            end else if (md_mode == MODE_RUN && is_exc(ms)) begin
                md_mode = MODE_DRAIN;
            end
        end
    endtask

    task automatic step(input logic rst_v, input logic st, input logic [3:0] di, sa, sb,
                        input logic [3:0] ei, edm, input logic ec,
                        input logic [3:0] mi, input logic [2:0] ms, ws);
        exp_t e;
        @(negedge clk);
        rst_n = rst_v; start = st;
        D_icode = di; d_srcA = sa; d_srcB = sb;
        E_icode = ei; E_dstM = edm; e_Cnd = ec;
        M_icode = mi; m_stat = ms; W_stat = ws;
        e = model_out(rst_v, di, sa, sb, ei, edm, ec, mi, ms, ws);
        exp_q.push_back(e);
        model_advance(rst_v, st, di, sa, sb, ei, edm, ec, mi, ms, ws);
    endtask

    task automatic rand_step(input logic st, input bit exc_ok);
        logic [3:0] di, sa, sb, ei, edm, mi;
        logic ec;
        logic [2:0] ms, ws;
        case ($urandom_range(0, 5))
            0: ei = 4'h5;
            1: ei = 4'hB;
            2: ei = 4'h7;
            3: ei = 4'h9;
            default: ei = 4'($urandom_range(0, 15));
        endcase
        edm = ($urandom_range(0, 5) == 0) ? 4'hF : 4'($urandom_range(0, 14));
        sa  = ($urandom_range(0, 2) == 0) ? edm : 4'($urandom_range(0, 15));
        sb  = ($urandom_range(0, 3) == 0) ? edm : 4'($urandom_range(0, 15));
        di  = ($urandom_range(0, 3) == 0) ? 4'h9 : 4'($urandom_range(0, 15));
        mi  = ($urandom_range(0, 5) == 0) ? 4'h9 : 4'($urandom_range(0, 15));
        ec  = 1'($urandom_range(0, 1));
        ms  = (exc_ok && $urandom_range(0, 7) == 0) ? 3'($urandom_range(2, 4)) : 3'($urandom_range(0, 1));
        ws  = (exc_ok && $urandom_range(0, 9) == 0) ? 3'($urandom_range(2, 7)) : 3'($urandom_range(0, 1));
        step(1'b1, st, di, sa, sb, ei, edm, ec, mi, ms, ws);
    endtask

    // Monitor: samples a quarter period after the driver updates inputs.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #(CLK_HALF / 2);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("ctrl_w32", 64'({F_stall_a, D_stall_a, D_bubble_a, E_bubble_a, M_bubble_a, W_stall_a}), 64'(e.ctrl));
                check("ctrl_w4",  64'({F_stall_s, D_stall_s, D_bubble_s, E_bubble_s, M_bubble_s, W_stall_s}), 64'(e.ctrl));
                check("halted",     64'({halted_a, halted_s}), 64'({e.halted, e.halted}));
                check("final_stat", 64'({final_stat_a, final_stat_s}), 64'({e.fstat, e.fstat}));
                check("cycle_cnt",  64'(cycle_cnt_a), 64'(e.cyc));
                check("lu_cnt",     64'(lu_cnt_a), 64'(e.lu));
                check("mp_cnt",     64'(mp_cnt_a), 64'(e.mp));
                check("cycle_cnt4", 64'(cycle_cnt_s), 64'(e.cyc4));
                check("lu_cnt4",    64'(lu_cnt_s), 64'(e.lu4));
                check("mp_cnt4",    64'(mp_cnt_s), 64'(e.mp4));
            end
        end
    end

    initial begin
        #(200000);
        n_fail++;
        $display("FAIL watchdog: time limit reached, expected stimulus to finish");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        repeat (2) @(posedge clk);
        model_advance(1'b0, 1'b0, 4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1'b1, 4'h1, 3'd1, 3'd1);

        // Held in reset, then idle with random inputs and no start.
        repeat (2) step(1'b0, 1'b0, 4'h9, 4'h3, 4'h3, 4'h5, 4'h3, 1'b0, 4'h9, 3'd3, 3'd3);
        repeat (4) rand_step(1'b0, 1'b1);

        // Start, then the directed hazard cases.
        step(1'b1, 1'b1, 4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1'b1, 4'h1, 3'd1, 3'd1);
        step(1'b1, 1'b0, 4'h6, 4'h3, 4'hF, 4'h5, 4'h3, 1'b1, 4'h1, 3'd1, 3'd1);
        step(1'b1, 1'b0, 4'h6, 4'h1, 4'h2, 4'h7, 4'h4, 1'b0, 4'h1, 3'd1, 3'd1);
        step(1'b1, 1'b0, 4'h9, 4'h3, 4'h2, 4'h5, 4'h3, 1'b1, 4'h1, 3'd1, 3'd1);
        step(1'b1, 1'b0, 4'h2, 4'hF, 4'hF, 4'h5, 4'hF, 1'b1, 4'h1, 3'd1, 3'd1);
        step(1'b1, 1'b0, 4'h1, 4'h6, 4'h3, 4'hB, 4'h3, 1'b1, 4'h1, 3'd0, 3'd1);
        repeat (30) rand_step(1'($urandom_range(0, 1)), 1'b0);

        // Exception drain into halt, then start pulses that must be ignored.
        step(1'b1, 1'b0, 4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1'b1, 4'h1, 3'd3, 3'd1);
        step(1'b1, 1'b0, 4'h5, 4'h2, 4'h2, 4'h5, 4'h2, 1'b0, 4'h1, 3'd1, 3'd1);
        step(1'b1, 1'b1, 4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1'b1, 4'h1, 3'd0, 3'd0);
        step(1'b1, 1'b0, 4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1'b1, 4'h1, 3'd0, 3'd3);
        repeat (4) rand_step(1'b1, 1'b1);

        // Reset in the middle of a drain.
        step(1'b0, 1'b0, 4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1'b1, 4'h1, 3'd1, 3'd1);
        step(1'b1, 1'b1, 4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1'b1, 4'h1, 3'd1, 3'd1);
        repeat (5) rand_step(1'b0, 1'b0);
        step(1'b1, 1'b0, 4'h1, 4'hF, 4'hF, 4'h7, 4'hF, 1'b0, 4'h1, 3'd4, 3'd1);
        step(1'b1, 1'b0, 4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1'b1, 4'h1, 3'd1, 3'd1);
        step(1'b0, 1'b1, 4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1'b1, 4'h1, 3'd1, 3'd1);
        repeat (3) rand_step(1'b0, 1'b1);

        // Long run past 4-bit saturation, then random episodes with faults.
        step(1'b1, 1'b1, 4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1'b1, 4'h1, 3'd1, 3'd1);
        repeat (24) rand_step(1'b0, 1'b0);
        for (int ep = 0; ep < 6; ep++) begin
            step(1'b0, 1'b0, 4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1'b1, 4'h1, 3'd1, 3'd1);
            repeat ($urandom_range(1, 3)) rand_step(1'b0, 1'b1);
            step(1'b1, 1'b1, 4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1'b1, 4'h1, 3'd1, 3'd1);
            repeat (40) rand_step(1'($urandom_range(0, 7) == 0), 1'b1);
        end

        repeat (3) @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
